// File: rtl/fft_pkg.sv
// Shared widths, twiddle codes, FSM encoding and the saturating narrow helper
// for the 8-point FFT datapath stages.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int HALF_N = 4;
  localparam int Q_FRAC = 8;

  localparam logic [1:0] TW_W0 = 2'd0;
  localparam logic [1:0] TW_W1 = 2'd1;
  localparam logic [1:0] TW_MJ = 2'd2;
  localparam logic [1:0] TW_W3 = 2'd3;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    COMB  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Clamp a one-bit-wider two's-complement value into DATA_W bits.
  function automatic logic [DATA_W-1:0] sat_narrow(input logic [DATA_W:0] v);
    logic [DATA_W-1:0] r;
    if (v[DATA_W] != v[DATA_W-1]) begin
      r = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_cadd_sat.sv
// Complex add (SUB=0) or subtract (SUB=1) of Q8.8 samples.
// FFT_BFLY_SAT_EN selects clamping on overflow; otherwise results wrap.
module fft_cadd_sat
  import fft_pkg::*;
#(
  parameter bit SUB = 1'b0
) (
  input  logic [DATA_W-1:0] a_re_i,
  input  logic [DATA_W-1:0] a_im_i,
  input  logic [DATA_W-1:0] b_re_i,
  input  logic [DATA_W-1:0] b_im_i,
  output logic [DATA_W-1:0] y_re_o,
  output logic [DATA_W-1:0] y_im_o
);

`ifdef FFT_BFLY_SAT_EN
  logic [DATA_W:0] w_re_s;
  logic [DATA_W:0] w_im_s;

  // Sign-extended one-bit-wider result so overflow is visible before clamping.
  always_comb begin
    if (SUB) begin
      w_re_s = {a_re_i[DATA_W-1], a_re_i} - {b_re_i[DATA_W-1], b_re_i};
      w_im_s = {a_im_i[DATA_W-1], a_im_i} - {b_im_i[DATA_W-1], b_im_i};
    end else begin
      w_re_s = {a_re_i[DATA_W-1], a_re_i} + {b_re_i[DATA_W-1], b_re_i};
      w_im_s = {a_im_i[DATA_W-1], a_im_i} + {b_im_i[DATA_W-1], b_im_i};
    end
  end

  assign y_re_o = sat_narrow(w_re_s);
  assign y_im_o = sat_narrow(w_im_s);
`else
  // Dropping the carry bit of the wide result is plain modulo-2^DATA_W arithmetic.
  always_comb begin
    if (SUB) begin
      y_re_o = a_re_i - b_re_i;
      y_im_o = a_im_i - b_im_i;
    end else begin
      y_re_o = a_re_i + b_re_i;
      y_im_o = a_im_i + b_im_i;
    end
  end
`endif

endmodule

// File: rtl/fft8_dif_bfly_sdf.sv
// Radix-2 DIF single-delay-feedback butterfly, first stage of the 8-point FFT.
// Saturation of sums/diffs is enabled by defining FFT_BFLY_SAT_EN.
module fft8_dif_bfly_sdf
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_diff,
  output logic [1:0]        tw_code,
  output logic              mul_flag
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] dly_re_q [HALF_N];
  logic [DATA_W-1:0] dly_im_q [HALF_N];

  logic [DATA_W-1:0] out_real_q, out_real_d;
  logic [DATA_W-1:0] out_imag_q, out_imag_d;
  logic              out_valid_q, out_valid_d;
  logic              out_diff_q, out_diff_d;
  logic [1:0]        tw_code_q, tw_code_d;

  logic              out_adv_s;
  logic              in_ready_s;
  logic              dly_we_s;
  logic [DATA_W-1:0] dly_wre_s, dly_wim_s;
  logic [DATA_W-1:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;

  fft_cadd_sat #(.SUB(1'b0)) u_sum (
    .a_re_i (dly_re_q[idx_q]),
    .a_im_i (dly_im_q[idx_q]),
    .b_re_i (in_real),
    .b_im_i (in_imag),
    .y_re_o (sum_re_s),
    .y_im_o (sum_im_s)
  );

  fft_cadd_sat #(.SUB(1'b1)) u_dif (
    .a_re_i (dly_re_q[idx_q]),
    .a_im_i (dly_im_q[idx_q]),
    .b_re_i (in_real),
    .b_im_i (in_imag),
    .y_re_o (dif_re_s),
    .y_im_o (dif_im_s)
  );

  assign out_adv_s = !out_valid_q || out_ready;

  // Phase sequencing, delay-line write selection and output register next state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_s  = 1'b0;
    dly_we_s    = 1'b0;
    dly_wre_s   = in_real;
    dly_wim_s   = in_imag;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    out_diff_d  = out_diff_q;
    tw_code_d   = tw_code_q;
    out_valid_d = out_valid_q;

    if (out_adv_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      FILL: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          dly_we_s = 1'b1;
          idx_d    = idx_q + 2'd1;
          state_d  = (idx_q == 2'd3) ? COMB : FILL;
        end else begin
          idx_d = idx_q;
        end
      end
      COMB: begin
        in_ready_s = out_adv_s;
        if (in_valid && out_adv_s) begin
          out_valid_d = 1'b1;
          out_real_d  = sum_re_s;
          out_imag_d  = sum_im_s;
          out_diff_d  = 1'b0;
          tw_code_d   = TW_W0;
          dly_we_s    = 1'b1;
          dly_wre_s   = dif_re_s;
          dly_wim_s   = dif_im_s;
          idx_d       = idx_q + 2'd1;
          state_d     = (idx_q == 2'd3) ? DRAIN : COMB;
        end else begin
          idx_d = idx_q;
        end
      end
      DRAIN: begin
        if (out_adv_s) begin
          out_valid_d = 1'b1;
          out_real_d  = dly_re_q[idx_q];
          out_imag_d  = dly_im_q[idx_q];
          out_diff_d  = 1'b1;
          tw_code_d   = idx_q;
          idx_d       = idx_q + 2'd1;
          state_d     = (idx_q == 2'd3) ? FILL : DRAIN;
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State, counter, delay line and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_real_q  <= {DATA_W{1'b0}};
      out_imag_q  <= {DATA_W{1'b0}};
      out_diff_q  <= 1'b0;
      tw_code_q   <= 2'd0;
      for (int i = 0; i < HALF_N; i++) begin
        dly_re_q[i] <= {DATA_W{1'b0}};
        dly_im_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_diff_q  <= out_diff_d;
      tw_code_q   <= tw_code_d;
      if (dly_we_s) begin
        dly_re_q[idx_q] <= dly_wre_s;
        dly_im_q[idx_q] <= dly_wim_s;
      end else begin
        dly_re_q[idx_q] <= dly_re_q[idx_q];
        dly_im_q[idx_q] <= dly_im_q[idx_q];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_valid = out_valid_q;
  assign out_diff  = out_diff_q;
  assign tw_code   = tw_code_q;
  assign mul_flag  = (tw_code_q == TW_W1);

endmodule

// File: tb/tb_fft8_dif_bfly_sdf.sv
// Bench for fft8_dif_bfly_sdf: per-frame reference of sums then twiddle-tagged
// diffs, compared in order against every result the DUT hands over.
module tb_fft8_dif_bfly_sdf;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        diff;
    logic [1:0]  tw;
    logic        mul;
  } res_t;

  logic        clk, rst_n;
  logic [15:0] in_real, in_imag, out_real, out_imag;
  logic        in_valid, in_ready, out_valid, out_ready, out_diff, mul_flag;
  logic [1:0]  tw_code;
  logic        rdy_rand_en, rdy_rand, rdy_val;

  int n_vec = 0;
  int n_err = 0;

  logic signed [15:0] fr_re [8];
  logic signed [15:0] fr_im [8];
  res_t obs_q[$];
  res_t exp_q[$];

  fft8_dif_bfly_sdf dut (
    .clk(clk), .rst_n(rst_n),
    .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid), .in_ready(in_ready),
    .out_real(out_real), .out_imag(out_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .tw_code(tw_code), .mul_flag(mul_flag)
  );

  assign out_ready = rdy_rand_en ? rdy_rand : rdy_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rdy_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1 rdy_rand = 1'($urandom_range(0, 1));
    end
  end

  // Record every handed-over result; it transfers on the following rising edge.
  always @(negedge clk) begin
    res_t r;
    if (rst_n && out_valid && out_ready) begin
      r.re = out_real; r.im = out_imag; r.diff = out_diff; r.tw = tw_code; r.mul = mul_flag;
      obs_q.push_back(r);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] reduce(input int v);
    logic [15:0] r;
    r = v[15:0];
`ifdef FFT_BFLY_SAT_EN
    if (v > 32767) r = 16'h7FFF;
    else if (v < -32768) r = 16'h8000;
`endif
    return r;
  endfunction

  function automatic res_t mask(input res_t r);
    res_t m;
    m = r;
    if (!m.diff) begin
      m.tw = 2'd0;
      m.mul = 1'b0;
    end
    return m;
  endfunction

  // Expected 8 results of the frame held in fr_re/fr_im.
  task automatic model_frame();
    res_t r;
    for (int n = 0; n < 4; n++) begin
      r.re = reduce(int'(fr_re[n]) + int'(fr_re[n+4]));
      r.im = reduce(int'(fr_im[n]) + int'(fr_im[n+4]));
      r.diff = 1'b0; r.tw = 2'd0; r.mul = 1'b0;
      exp_q.push_back(r);
    end
    for (int n = 0; n < 4; n++) begin
      r.re = reduce(int'(fr_re[n]) - int'(fr_re[n+4]));
      r.im = reduce(int'(fr_im[n]) - int'(fr_im[n+4]));
      r.diff = 1'b1; r.tw = 2'(n); r.mul = (n == 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic push_sample(input logic [15:0] re, input logic [15:0] im);
    bit done;
    done = 1'b0;
    in_real = re; in_imag = im; in_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL push_timeout in_ready got 0 for 200 cycles, want 1");
    end
  endtask

  task automatic run_frame(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      push_sample(fr_re[i], fr_im[i]);
    end
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 1000 && obs_q.size() < n; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_real = 16'h0000; in_imag = 16'h0000;
    rdy_rand_en = 1'b0; rdy_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_real !== 16'h0000) begin n_err++; $display("FAIL rst_out_real got %h want 0000", out_real); end
    n_vec++; if (out_imag !== 16'h0000) begin n_err++; $display("FAIL rst_out_imag got %h want 0000", out_imag); end
    n_vec++; if (out_diff !== 1'b0) begin n_err++; $display("FAIL rst_out_diff got %b want 0", out_diff); end
    n_vec++; if (tw_code !== 2'd0) begin n_err++; $display("FAIL rst_tw_code got %0d want 0", tw_code); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_unity();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin fr_re[i] = 16'sh0100; fr_im[i] = 16'sh0000; end
    model_frame();
    run_frame(0, 7, 0);
    wait_results(8);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL unity_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_vec++;
      if (mask(obs_q[k]) !== mask(exp_q[k])) begin
        n_err++;
        $display("FAIL unity_res%0d got re=%h im=%h d=%b tw=%0d m=%b want re=%h im=%h d=%b tw=%0d m=%b", k,
                 obs_q[k].re, obs_q[k].im, obs_q[k].diff, obs_q[k].tw, obs_q[k].mul,
                 exp_q[k].re, exp_q[k].im, exp_q[k].diff, exp_q[k].tw, exp_q[k].mul);
      end
    end
    if (obs_q.size() == 8) begin
      n_vec++; if (obs_q[0].re !== 16'h0200) begin n_err++; $display("FAIL unity_sum0 got %h want 0200", obs_q[0].re); end
      n_vec++; if (obs_q[5].mul !== 1'b1) begin n_err++; $display("FAIL unity_mul1 got %b want 1", obs_q[5].mul); end
    end
  endtask

  task automatic test_ramp();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin fr_re[i] = 16'(i * 256); fr_im[i] = 16'sh0000; end
    model_frame();
    run_frame(0, 7, 2);
    wait_results(8);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ramp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_vec++;
      if (mask(obs_q[k]) !== mask(exp_q[k])) begin
        n_err++;
        $display("FAIL ramp_res%0d got re=%h im=%h d=%b tw=%0d want re=%h im=%h d=%b tw=%0d", k,
                 obs_q[k].re, obs_q[k].im, obs_q[k].diff, obs_q[k].tw,
                 exp_q[k].re, exp_q[k].im, exp_q[k].diff, exp_q[k].tw);
      end
    end
    if (obs_q.size() == 8) begin
      n_vec++; if (obs_q[7].re !== 16'hFC00) begin n_err++; $display("FAIL ramp_diff3 got %h want FC00", obs_q[7].re); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] want_sum0, want_dif1;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin fr_re[i] = 16'sh0000; fr_im[i] = 16'sh0000; end
    fr_re[0] = 16'sh7000; fr_re[4] = 16'sh7000; fr_re[1] = 16'sh8000; fr_re[5] = 16'sh7000;
    fr_im[2] = 16'sh8000; fr_im[6] = 16'sh0001;
`ifdef FFT_BFLY_SAT_EN
    want_sum0 = 16'h7FFF; want_dif1 = 16'h8000;
`else
    want_sum0 = 16'hE000; want_dif1 = 16'h1000;
`endif
    model_frame();
    run_frame(0, 7, 1);
    wait_results(8);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_vec++;
      if (mask(obs_q[k]) !== mask(exp_q[k])) begin
        n_err++;
        $display("FAIL ovf_res%0d got re=%h im=%h d=%b tw=%0d want re=%h im=%h d=%b tw=%0d", k,
                 obs_q[k].re, obs_q[k].im, obs_q[k].diff, obs_q[k].tw,
                 exp_q[k].re, exp_q[k].im, exp_q[k].diff, exp_q[k].tw);
      end
    end
    if (obs_q.size() == 8) begin
      n_vec++; if (obs_q[0].re !== want_sum0) begin n_err++; $display("FAIL ovf_sum0 got %h want %h", obs_q[0].re, want_sum0); end
      n_vec++; if (obs_q[5].re !== want_dif1) begin n_err++; $display("FAIL ovf_dif1 got %h want %h", obs_q[5].re, want_dif1); end
    end
  endtask

  task automatic test_backpressure();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin fr_re[i] = 16'(i * 256); fr_im[i] = 16'sh0000; end
    model_frame();
    run_frame(0, 5, 0);
    rdy_val = 1'b0;
    in_real = fr_re[6]; in_imag = fr_im[6]; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, in_ready); end
      n_vec++;
      if (out_valid !== 1'b1 || out_real !== exp_q[1].re || out_imag !== exp_q[1].im || out_diff !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cyc%0d got v=%b re=%h im=%h d=%b want v=1 re=%h im=%h d=0", c,
                 out_valid, out_real, out_imag, out_diff, exp_q[1].re, exp_q[1].im);
      end
      @(posedge clk);
      #1;
    end
    rdy_val = 1'b1;
    run_frame(6, 7, 0);
    wait_results(8);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_vec++;
      if (mask(obs_q[k]) !== mask(exp_q[k])) begin
        n_err++;
        $display("FAIL bp_res%0d got re=%h im=%h d=%b tw=%0d want re=%h im=%h d=%b tw=%0d", k,
                 obs_q[k].re, obs_q[k].im, obs_q[k].diff, obs_q[k].tw,
                 exp_q[k].re, exp_q[k].im, exp_q[k].diff, exp_q[k].tw);
      end
    end
  endtask

  task automatic test_reset_drain();
    bit found;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin fr_re[i] = 16'($urandom); fr_im[i] = 16'($urandom); end
    run_frame(0, 7, 0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      found = out_valid && out_diff && (tw_code == 2'd1);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rd_reach_drain got 0 want 1"); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rd_drain_in_ready got %b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rd_out_valid got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin fr_re[i] = 16'sh0100; fr_im[i] = 16'sh0000; end
    model_frame();
    run_frame(0, 7, 0);
    wait_results(8);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_vec++;
      if (mask(obs_q[k]) !== mask(exp_q[k])) begin
        n_err++;
        $display("FAIL rd_res%0d got re=%h im=%h d=%b tw=%0d m=%b want re=%h im=%h d=%b tw=%0d m=%b", k,
                 obs_q[k].re, obs_q[k].im, obs_q[k].diff, obs_q[k].tw, obs_q[k].mul,
                 exp_q[k].re, exp_q[k].im, exp_q[k].diff, exp_q[k].tw, exp_q[k].mul);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    rdy_rand_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin fr_re[i] = 16'($urandom); fr_im[i] = 16'($urandom); end
      model_frame();
      run_frame(0, 7, 3);
    end
    wait_results(16);
    rdy_rand_en = 1'b0;
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_vec++;
      if (mask(obs_q[k]) !== mask(exp_q[k])) begin
        n_err++;
        $display("FAIL b2b_res%0d got re=%h im=%h d=%b tw=%0d m=%b want re=%h im=%h d=%b tw=%0d m=%b", k,
                 obs_q[k].re, obs_q[k].im, obs_q[k].diff, obs_q[k].tw, obs_q[k].mul,
                 exp_q[k].re, exp_q[k].im, exp_q[k].diff, exp_q[k].tw, exp_q[k].mul);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_real = 16'h0000; in_imag = 16'h0000;
    rdy_rand_en = 1'b0; rdy_val = 1'b1;
    test_reset();
    test_unity();
    test_ramp();
    test_overflow();
    test_backpressure();
    test_reset_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
